// File: rtl/ex_trap_pkg.sv
// ex_trap_pkg: shared state encoding and default parameters for the external trap responder
package ex_trap_pkg;
    typedef enum logic [1:0] {IDLE, REQ, ACK} state_e;
    localparam int          SYNC_STAGES_DEF = 2;
    localparam logic [15:0] TIMEOUT_DEF     = 16'd1000;
endpackage

// File: rtl/sync_dff.sv
// sync_dff: DEPTH-flop synchronizer for one asynchronous bit
//   clk, rst_n : clock, async active-low reset (clears every stage)
//   d          : asynchronous input
//   q          : synchronized output, DEPTH edges behind d
module sync_dff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] ff;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ff <= '0;
        else        ff <= {ff[DEPTH-2:0], d};
    assign q = ff[DEPTH-1];
endmodule

// File: rtl/ex_trap_resp.sv
// ex_trap_resp: four-phase external trap handshake turned into a core interrupt request
//   clk, rst_n      : clock, async active-low reset
//   ex_trap_valid_i : asynchronous trap request pin (synchronized before use)
//   ex_trap_ready_o : acknowledge back to the initiator, high while the trap is taken
//   irq_en_i        : core external-interrupt enable; masks the request and freezes the wait timer
//   irq_ack_i       : core took the trap
//   irq_req_o       : interrupt request to the core
//   clr_i           : clears the sticky timeout flag
//   timeout_o       : request left unacknowledged for TIMEOUT enabled cycles
//   trap_cnt_o      : completed handshakes, wrapping
module ex_trap_resp
    import ex_trap_pkg::*;
#(
    parameter int          SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic [15:0] TIMEOUT     = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_trap_valid_i,
    output logic        ex_trap_ready_o,
    input  logic        irq_en_i,
    input  logic        irq_ack_i,
    output logic        irq_req_o,
    input  logic        clr_i,
    output logic        timeout_o,
    output logic [15:0] trap_cnt_o
);
    // With the timeout disabled the wait counter just parks at all-ones.
    localparam logic [15:0] WAIT_MAX = (TIMEOUT == 16'd0) ? 16'hFFFF : TIMEOUT;
    state_e      state;
    logic        vs;
    logic [15:0] wait_cnt;
    logic        to_set;
    sync_dff #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ex_trap_valid_i),
        .q    (vs)
    );
    assign irq_req_o       = (state == REQ) & irq_en_i;
    assign ex_trap_ready_o = state == ACK;
    // Fires only on the edge the counter reaches TIMEOUT, so a cleared flag stays clear afterwards.
    assign to_set = irq_req_o && (TIMEOUT != 16'd0) && (wait_cnt == TIMEOUT - 16'd1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            trap_cnt_o <= '0;
            timeout_o  <= 1'b0;
        end else begin
            timeout_o <= to_set ? 1'b1 : (clr_i ? 1'b0 : timeout_o);
            if (irq_req_o && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 16'd1;
            case (state)
                IDLE: if (vs) begin
                    state    <= REQ;
                    wait_cnt <= '0;
                end
                // An ack wins over a withdrawal seen on the same edge.
                REQ: if (irq_ack_i) begin
                    state      <= ACK;
                    trap_cnt_o <= trap_cnt_o + 16'd1;
                end else if (!vs) state <= IDLE;
                ACK: if (!vs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_ex_trap_resp.sv
// tb_ex_trap_resp: directed scenarios plus randomized run against a behavioural model
module tb_ex_trap_resp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic        en = 1'b1;
    logic        ack = 1'b0;
    logic        req;
    logic        clr = 1'b0;
    logic        to;
    logic [15:0] cnt;
    int          checks = 0;
    int          errors = 0;

    ex_trap_resp #(.SYNC_STAGES(2), .TIMEOUT(16'd8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_trap_valid_i(valid),
        .ex_trap_ready_o(ready),
        .irq_en_i       (en),
        .irq_ack_i      (ack),
        .irq_req_o      (req),
        .clr_i          (clr),
        .timeout_o      (to),
        .trap_cnt_o     (cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!req && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid = 1'b0; en = 1'b1; ack = 1'b0; clr = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({req, ready, to, cnt} !== 19'd0) begin
            errors++;
            $display("FAIL reset_async: req=%b ready=%b to=%b cnt=%0d want all 0", req, ready, to, cnt);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({req, ready, to, cnt} !== 19'd0) begin
            errors++;
            $display("FAIL reset_idle: req=%b ready=%b to=%b cnt=%0d want all 0", req, ready, to, cnt);
        end
    endtask

    task automatic test_basic();
        int n;
        en = 1'b1; valid = 1'b1;
        wait_req(n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL basic_latency: edges=%0d want 3", n); end
        repeat (4) tick();
        checks++;
        if (req !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL basic_hold: req=%b ready=%b want 1 0", req, ready);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (ready !== 1'b1 || req !== 1'b0) begin
            errors++; $display("FAIL basic_ready: ready=%b req=%b want 1 0", ready, req);
        end
        valid = 1'b0;
        n = 0;
        while (ready && n < 10) begin tick(); n++; end
        checks++;
        if (ready !== 1'b0 || n < 1 || n > 3) begin
            errors++; $display("FAIL basic_release: ready=%b edges=%0d want 0 within 1..3", ready, n);
        end
        checks++;
        if (cnt !== 16'd1) begin errors++; $display("FAIL basic_count: cnt=%0d want 1", cnt); end
    endtask

    task automatic test_withdraw();
        bit saw_req = 0, saw_ready = 0;
        valid = 1'b1;
        repeat (4) begin tick(); saw_req |= req; saw_ready |= ready; end
        valid = 1'b0;
        repeat (6) begin tick(); saw_ready |= ready; end
        checks++;
        if (saw_req !== 1'b1 || req !== 1'b0 || saw_ready !== 1'b0) begin
            errors++;
            $display("FAIL withdraw: saw_req=%b req=%b saw_ready=%b want 1 0 0", saw_req, req, saw_ready);
        end
        checks++;
        if (cnt !== 16'd1) begin errors++; $display("FAIL withdraw_count: cnt=%0d want 1", cnt); end
    endtask

    task automatic test_timeout();
        int n;
        valid = 1'b1;
        wait_req(n);
        repeat (7) tick();
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL timeout_early: to=%b want 0", to); end
        tick();
        checks++;
        if (to !== 1'b1 || req !== 1'b1) begin
            errors++; $display("FAIL timeout_set: to=%b req=%b want 1 1", to, req);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL timeout_clr: to=%b want 0", to); end
        valid = 1'b0;
        repeat (4) tick();
        valid = 1'b1;
        wait_req(n);
        repeat (7) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (to !== 1'b1) begin errors++; $display("FAIL timeout_set_wins: to=%b want 1", to); end
        clr = 1'b1; tick(); clr = 1'b0;
        valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_mask();
        en = 1'b0; valid = 1'b1;
        repeat (23) tick();
        checks++;
        if (req !== 1'b0 || to !== 1'b0) begin
            errors++; $display("FAIL mask_hold: req=%b to=%b want 0 0", req, to);
        end
        en = 1'b1;
        tick();
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL mask_release: req=%b want 1", req); end
        repeat (6) tick();
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL mask_frozen: to=%b want 0", to); end
        tick();
        checks++;
        if (to !== 1'b1) begin errors++; $display("FAIL mask_timeout: to=%b want 1", to); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (ready !== 1'b1 || cnt !== 16'd2) begin
            errors++; $display("FAIL mask_ack: ready=%b cnt=%0d want 1 2", ready, cnt);
        end
        clr = 1'b1; valid = 1'b0; tick(); clr = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_wrap_priority();
        int n;
        force dut.trap_cnt_o = 16'hFFFF;
        tick();
        release dut.trap_cnt_o;
        tick();
        checks++;
        if (cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: cnt=%0d want 65535", cnt); end
        valid = 1'b1;
        wait_req(n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL wrap_latency: edges=%0d want 3", n); end
        valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL prio_still_req: req=%b want 1", req); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (ready !== 1'b1 || cnt !== 16'd0) begin
            errors++; $display("FAIL prio_ack_wins: ready=%b cnt=%0d want 1 0", ready, cnt);
        end
        tick();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL prio_return: ready=%b want 0", ready); end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int n;
        valid = 1'b1;
        wait_req(n);
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: ready=%b want 1", ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || cnt !== 16'd0) begin
            errors++; $display("FAIL rstmid_async: ready=%b cnt=%0d want 0 0", ready, cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_req(n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL rstmid_restart: edges=%0d want 3", n); end
    endtask

    task automatic test_random();
        bit          sq0, sq1, vs, pend, gran, mto, set, v, e, a, c;
        int          wt, mcnt;
        logic [18:0] exp_v, got;
        do_reset();
        sq0 = 0; sq1 = 0; pend = 0; gran = 0; mto = 0; wt = 0; mcnt = 0; v = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) v = !v;
            e = $urandom_range(7) != 0;
            a = $urandom_range(9) == 0;
            c = $urandom_range(15) == 0;
            valid = v; en = e; ack = a; clr = c;
            vs = sq1;
            set = pend && e && (wt + 1 == 8);
            if (pend && e && wt < 8) wt++;
            mto = set ? 1'b1 : (c ? 1'b0 : mto);
            if (pend) begin
                if (a) begin pend = 0; gran = 1; mcnt = (mcnt + 1) % 65536; end
                else if (!vs) pend = 0;
            end else if (gran) begin
                if (!vs) gran = 0;
            end else if (vs) begin
                pend = 1; wt = 0;
            end
            sq1 = sq0; sq0 = v;
            tick();
            exp_v = {pend && e, gran, mto, 16'(mcnt)};
            got   = {req, ready, to, cnt};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: req/ready/to/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         i, got[18], got[17], got[16], got[15:0],
                         exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
            end
        end
        ack = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_withdraw();
        test_timeout();
        test_mask();
        test_wrap_priority();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_trap_resp.md
EX_TRAP_RESP -- requirements
Module: ex_trap_resp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock port clk, reset port rst_n.
REQ-002 Parameter SHALL be SYNC_STAGES, default 2, meaning synchronizer depth for ex_trap_valid_i (legal 2..4).
REQ-003 Parameter SHALL be TIMEOUT, default 16'd1000, meaning cycles of unacknowledged irq_req_o before timeout flag; 0 disables.
REQ-004 Ports SHALL be:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- ex_trap_valid_i  in  1  external trap request from pin, asynchronous to clk
- ex_trap_ready_o  out  1  handshake acknowledge to external initiator
- irq_en_i  in  1  core external-interrupt enable (MEIE & MIE)
- irq_ack_i  in  1  one-cycle pulse: core has taken the external trap
- irq_req_o  out  1  external interrupt request to core
- clr_i  in  1  one-cycle pulse: clear timeout flag
- timeout_o  out  1  sticky timeout flag
- trap_cnt_o  out  16  count of completed handshakes

Function
REQ-005 ex_trap_valid_i SHALL pass through a SYNC_STAGES flip-flop synchronizer; all logic SHALL use only the synchronized value vs.
REQ-006 FSM states SHALL be IDLE, REQ, ACK.
REQ-007 IDLE->REQ on the edge where vs==1; IDLE otherwise holds.
REQ-008 In REQ: irq_ack_i==1 -> ACK (takes priority over vs==0); else vs==0 -> IDLE (request withdrawn, not counted); else hold.
REQ-009 In ACK: vs==0 -> IDLE; else hold.
REQ-010 irq_req_o SHALL equal (state==REQ) & irq_en_i, registered-state-derived; no combinational path from ex_trap_valid_i.
REQ-011 ex_trap_ready_o SHALL be 1 exactly while state==ACK (four-phase: ready rises one edge after ack sampled, falls one edge after vs sampled 0).
REQ-012 Latency: pin valid stable high -> irq_req_o high after SYNC_STAGES+1 rising edges (irq_en_i=1).
REQ-013 irq_ack_i sampled in IDLE or ACK SHALL be ignored.
REQ-014 trap_cnt_o SHALL increment by 1 on each REQ->ACK transition, wrapping 0xFFFF->0x0000.
REQ-015 A 16-bit wait counter SHALL clear on entry to REQ, increment each cycle irq_req_o==1, and saturate at TIMEOUT.
REQ-016 When TIMEOUT!=0 and wait counter reaches TIMEOUT, timeout_o SHALL set on that edge and stay set; state remains REQ.
REQ-017 clr_i SHALL clear timeout_o next edge; simultaneous set and clr_i -> set wins.
REQ-018 irq_en_i low in REQ SHALL mask irq_req_o and freeze the wait counter without leaving REQ.
REQ-019 A new request SHALL NOT be accepted until vs has returned to 0 and the FSM has passed through IDLE.

Reset
REQ-020 On rst_n low, asynchronously: state=IDLE, synchronizer flops=0, irq_req_o=0, ex_trap_ready_o=0, timeout_o=0, trap_cnt_o=0, wait counter=0.
REQ-021 Reset asserted mid-handshake SHALL drop ex_trap_ready_o immediately; after release, a still-high valid SHALL start a fresh request (REQ-012 latency).

Structure
REQ-022 Package ex_trap_pkg SHALL hold the state enum and the default SYNC_STAGES/TIMEOUT constants.
REQ-023 Synchronizer SHALL be a separate sub-module sync_dff (parameterized depth, async active-low reset).

Verification
REQ-024 Basic: irq_en_i=1, valid 0->1, core acks 5 cycles after irq_req_o -> irq_req_o high at edge 3, ready high next edge, valid drop -> ready low within 3 edges, trap_cnt_o=1.
REQ-025 Withdrawal: valid high 4 cycles, no ack, then low -> irq_req_o falls, ready never asserts, trap_cnt_o unchanged.
REQ-026 Timeout: TIMEOUT=8, no ack -> timeout_o set after 8 cycles of irq_req_o; clr_i -> 0; clr_i coinciding with set edge -> stays 1.
REQ-027 Mask: irq_en_i=0 for 20 cycles in REQ -> irq_req_o=0, no timeout (TIMEOUT=8); irq_en_i=1 -> irq_req_o next cycle.
REQ-028 Wrap and priority: preload 65535 handshakes (or force count) -> next handshake gives trap_cnt_o=0; ack and vs==0 same cycle -> ACK, count increments.
REQ-029 Reset: assert rst_n=0 while ready=1 -> ready 0 without clock edge; release with valid high -> new request, irq_req_o after 3 edges.
